apb_led_sequencer: RTL and testbench

//  APB3 slave on the SoC's io_apbSlave_0 port that sequences the board LED bank.

---
 rtl/apb_led_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_apb_led_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_led_sequencer.sv
// APB3 LED bank sequencer.
// Software loads {pattern, duration} steps and sets CTRL.RUN. The block then plays the
// steps on o_led at a prescaled tick rate, either once or looping. When a one-shot
// sequence finishes it sets STATUS.DONE, which raises a level interrupt if CTRL.IRQ_EN is set.
// Optional feature macro: LEDSEQ_PWM_EN adds the BRIGHT register and PWM dimming of o_led.
module apb_led_sequencer #(
    parameter int unsigned NUM_STEPS = 8,
    parameter int unsigned DUR_W     = 16,
    parameter int unsigned PRE_W     = 16,
    parameter logic [7:0]  IDLE_LED  = 8'h00
) (
    input  logic        io_systemClk,
    input  logic        io_systemReset,
    input  logic [15:0] io_apbSlave_PADDR,
    input  logic        io_apbSlave_PSEL,
    input  logic        io_apbSlave_PENABLE,
    input  logic        io_apbSlave_PWRITE,
    input  logic [31:0] io_apbSlave_PWDATA,
    output logic [31:0] io_apbSlave_PRDATA,
    output logic        io_apbSlave_PREADY,
    output logic        io_apbSlave_PSLVERROR,
    output logic [7:0]  o_led,
    output logic        o_irq
);

    localparam int unsigned IW = $clog2(NUM_STEPS);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    // Register file and sequencer state
    state_e             state_q, state_d;
    logic               run_q, run_d;
    logic               loop_q, loop_d;
    logic               irq_en_q, irq_en_d;
    logic               done_q, done_d;
    logic [IW-1:0]      len_q, len_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [7:0]         pat_q, pat_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
    logic [7:0]         step_pat_q [NUM_STEPS];
    logic [DUR_W-1:0]   step_dur_q [NUM_STEPS];

    // Address decode (only PADDR[7:2] matters)
    logic [5:0]    word;
    logic          sel_ctrl, sel_status, sel_len, sel_pre, sel_bright, sel_step, mapped;
    logic [IW-1:0] step_sel;
    logic          wr;
    logic          tick, step_end;
    logic [IW-1:0] next_idx;
    logic [7:0]    led_base;
    logic          unused_bits;

    assign word        = io_apbSlave_PADDR[7:2];
    assign wr          = io_apbSlave_PSEL & io_apbSlave_PENABLE & io_apbSlave_PWRITE;
    assign unused_bits = ^{io_apbSlave_PADDR[15:8], io_apbSlave_PADDR[1:0], io_apbSlave_PWDATA};

    // Decode the word offset into register selects
    always_comb begin
        sel_ctrl   = (word == 6'h00);
        sel_status = (word == 6'h01);
        sel_len    = (word == 6'h02);
        sel_pre    = (word == 6'h03);
`ifdef LEDSEQ_PWM_EN
        sel_bright = (word == 6'h04);
`else
        sel_bright = 1'b0;
`endif
        // STEP[n] lives at word 16+n; 16 is aligned so the low bits are the slot index
        sel_step   = (word >= 6'd16) && (word < 6'(16 + NUM_STEPS));
        step_sel   = word[IW-1:0];
        mapped     = sel_ctrl | sel_status | sel_len | sel_pre | sel_bright | sel_step;
    end

    // Next-state for control registers and the sequencer FSM
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        loop_d    = loop_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        len_d     = len_q;
        pre_d     = pre_q;
        idx_d     = idx_q;
        pat_d     = pat_q;
        dur_d     = dur_q;
        pre_cnt_d = pre_cnt_q;
        dur_cnt_d = dur_cnt_q;
        tick      = 1'b0;
        step_end  = 1'b0;
        next_idx  = idx_q;

        if (wr && sel_ctrl) begin
            run_d    = io_apbSlave_PWDATA[0];
            loop_d   = io_apbSlave_PWDATA[1];
            irq_en_d = io_apbSlave_PWDATA[2];
        end
        if (wr && sel_len) len_d = io_apbSlave_PWDATA[IW-1:0];
        if (wr && sel_pre) pre_d = io_apbSlave_PWDATA[PRE_W-1:0];
        if (wr && sel_status && io_apbSlave_PWDATA[1]) done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (wr && sel_ctrl && io_apbSlave_PWDATA[0]) begin
                    state_d   = StRun;
                    idx_d     = '0;
                    pat_d     = step_pat_q[0];
                    dur_d     = step_dur_q[0];
                    pre_cnt_d = '0;
                    dur_cnt_d = '0;
                    done_d    = 1'b0;
                end
            end
            StRun: begin
                // Live compare so a shrunk PRESCALE cannot strand the counter above it
                if (pre_cnt_q >= pre_q) begin
                    tick      = 1'b1;
                    pre_cnt_d = '0;
                end else begin
                    pre_cnt_d = pre_cnt_q + PRE_W'(1);
                end
                if (tick) begin
                    if (dur_cnt_q == dur_q) step_end = 1'b1;
                    else                    dur_cnt_d = dur_cnt_q + DUR_W'(1);
                end
                // Software stop; a natural end on the same edge overrides below and sets DONE
                if (wr && sel_ctrl && !io_apbSlave_PWDATA[0]) state_d = StIdle;
                if (step_end) begin
                    dur_cnt_d = '0;
                    if (idx_q >= len_q) begin
                        next_idx = '0;
                        if (!loop_q) begin
                            state_d = StIdle;
                            run_d   = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        next_idx = idx_q + IW'(1);
                    end
                    idx_d = next_idx;
                    pat_d = step_pat_q[next_idx];
                    dur_d = step_dur_q[next_idx];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control/sequencer state registers
    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            state_q   <= StIdle;
            run_q     <= 1'b0;
            loop_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            len_q     <= '0;
            pre_q     <= '0;
            idx_q     <= '0;
            pat_q     <= '0;
            dur_q     <= '0;
            pre_cnt_q <= '0;
            dur_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            loop_q    <= loop_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            len_q     <= len_d;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            pat_q     <= pat_d;
            dur_q     <= dur_d;
            pre_cnt_q <= pre_cnt_d;
            dur_cnt_q <= dur_cnt_d;
        end
    end

    // Step slot storage; running steps only see a rewrite when the slot is next entered
    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                step_pat_q[i] <= '0;
                step_dur_q[i] <= '0;
            end
        end else if (wr && sel_step) begin
            step_pat_q[step_sel] <= io_apbSlave_PWDATA[7:0];
            step_dur_q[step_sel] <= io_apbSlave_PWDATA[DUR_W+7:8];
        end
    end

    assign led_base = (state_q == StRun) ? pat_q : IDLE_LED;

`ifdef LEDSEQ_PWM_EN
    logic [7:0] bright_q;
    logic [7:0] pwm_cnt_q;

    // Brightness register and free-running PWM counter
    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            bright_q  <= 8'hFF;
            pwm_cnt_q <= 8'h00;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            if (wr && sel_bright) bright_q <= io_apbSlave_PWDATA[7:0];
        end
    end

    assign o_led = led_base & {8{pwm_cnt_q < bright_q}};
`else
    assign o_led = led_base;
`endif

    assign o_irq              = done_q & irq_en_q;
    assign io_apbSlave_PREADY = 1'b1;
    assign io_apbSlave_PSLVERROR = io_apbSlave_PSEL & ~mapped;

    // Combinational read mux; zero when not selected or unmapped
    always_comb begin
        io_apbSlave_PRDATA = '0;
        if (io_apbSlave_PSEL) begin
            if (sel_ctrl) begin
                io_apbSlave_PRDATA[0] = run_q;
                io_apbSlave_PRDATA[1] = loop_q;
                io_apbSlave_PRDATA[2] = irq_en_q;
            end else if (sel_status) begin
                io_apbSlave_PRDATA[0]      = (state_q == StRun);
                io_apbSlave_PRDATA[1]      = done_q;
                io_apbSlave_PRDATA[IW+3:4] = idx_q;
            end else if (sel_len) begin
                io_apbSlave_PRDATA[IW-1:0] = len_q;
            end else if (sel_pre) begin
                io_apbSlave_PRDATA[PRE_W-1:0] = pre_q;
            end else if (sel_step) begin
                io_apbSlave_PRDATA[7:0]       = step_pat_q[step_sel];
                io_apbSlave_PRDATA[DUR_W+7:8] = step_dur_q[step_sel];
            end
`ifdef LEDSEQ_PWM_EN
            else if (sel_bright) begin
                io_apbSlave_PRDATA[7:0] = bright_q;
            end
`endif
        end
    end

endmodule

// File: tb/tb_apb_led_sequencer.sv
// Directed bench for apb_led_sequencer (default build, LEDSEQ_PWM_EN undefined).
module tb_apb_led_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic [7:0]  led;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    apb_led_sequencer dut (
        .io_systemClk         (clk),
        .io_systemReset       (rst),
        .io_apbSlave_PADDR    (paddr),
        .io_apbSlave_PSEL     (psel),
        .io_apbSlave_PENABLE  (penable),
        .io_apbSlave_PWRITE   (pwrite),
        .io_apbSlave_PWDATA   (pwdata),
        .io_apbSlave_PRDATA   (prdata),
        .io_apbSlave_PREADY   (pready),
        .io_apbSlave_PSLVERROR(pslverr),
        .o_led                (led),
        .o_irq                (irq)
    );

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d, output logic err);
        @(posedge clk);
        #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk);
        #1 penable = 1'b1;
        #1 err = pslverr;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [31:0] d, output logic err);
        @(posedge clk);
        #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk);
        #1 penable = 1'b1;
        #1 d = prdata; err = pslverr;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
    endtask

    function automatic logic [7:0] exp_led(input int k);
        if (k < 8)  return 8'hA5;
        if (k < 12) return 8'h5A;
        if (k < 24) return 8'hFF;
        return 8'h00;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        e;

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;

        vecs[0]  = '{16'h0000, 1'b0, 32'h0,        32'h0000_0000, 1'b0};
        vecs[1]  = '{16'h0004, 1'b0, 32'h0,        32'h0000_0000, 1'b0};
        vecs[2]  = '{16'h000C, 1'b1, 32'hFFFF_0003, 32'h0,        1'b0};
        vecs[3]  = '{16'h000C, 1'b0, 32'h0,        32'h0000_0003, 1'b0};
        vecs[4]  = '{16'h0008, 1'b1, 32'hFFFF_FFFA, 32'h0,        1'b0};
        vecs[5]  = '{16'h0008, 1'b0, 32'h0,        32'h0000_0002, 1'b0};
        vecs[6]  = '{16'h0040, 1'b1, 32'hFF01_23A5, 32'h0,        1'b0};
        vecs[7]  = '{16'h0040, 1'b0, 32'h0,        32'h0001_23A5, 1'b0};
        vecs[8]  = '{16'h0080, 1'b1, 32'h0000_1234, 32'h0,        1'b1};
        vecs[9]  = '{16'h0080, 1'b0, 32'h0,        32'h0000_0000, 1'b1};
        vecs[10] = '{16'h000C, 1'b0, 32'h0,        32'h0000_0003, 1'b0};
        vecs[11] = '{16'h005C, 1'b0, 32'h0,        32'h0000_0000, 1'b0};
        vecs[12] = '{16'h0060, 1'b0, 32'h0,        32'h0000_0000, 1'b1};
        vecs[13] = '{16'h0010, 1'b1, 32'h0000_00AA, 32'h0,        1'b1};
        vecs[14] = '{16'h0010, 1'b0, 32'h0,        32'h0000_0000, 1'b1};
        vecs[15] = '{16'h0004, 1'b1, 32'hFFFF_FFFF, 32'h0,        1'b0};
        vecs[16] = '{16'h0004, 1'b0, 32'h0,        32'h0000_0000, 1'b0};
        vecs[17] = '{16'h0000, 1'b0, 32'h0,        32'h0000_0000, 1'b0};

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_led",    32'(led),     32'h00);
        check("reset_prdata", prdata,       32'h0);
        check("reset_irq",    32'(irq),     32'h0);
        check("reset_pready", 32'(pready),  32'h1);
        check("reset_err",    32'(pslverr), 32'h0);

        // Register access table
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].wdata, e);
                check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            end else begin
                apb_read(vecs[i].addr, rd, e);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
                check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            end
        end

        // One-shot timing
        apb_write(16'h0040, 32'h0000_01A5, e);
        apb_write(16'h0044, 32'h0000_005A, e);
        apb_write(16'h0048, 32'h0000_02FF, e);
        apb_write(16'h0008, 32'h2, e);
        apb_write(16'h000C, 32'h3, e);
        apb_write(16'h0000, 32'h5, e);
        for (int k = 0; k < 26; k++) begin
            check($sformatf("oneshot_led_c%0d", k), 32'(led), 32'(exp_led(k)));
            @(posedge clk);
            #1;
        end
        check("oneshot_irq", 32'(irq), 32'h1);
        apb_read(16'h0004, rd, e);
        check("oneshot_status", rd & 32'h3, 32'h2);
        apb_read(16'h0000, rd, e);
        check("oneshot_ctrl", rd, 32'h4);
        apb_write(16'h0004, 32'h2, e);
        apb_read(16'h0004, rd, e);
        check("w1c_status", rd & 32'h3, 32'h0);
        check("w1c_irq", 32'(irq), 32'h0);

        // Looping, then software stop in the middle of step 1
        apb_write(16'h0000, 32'h3, e);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("loop_led_c%0d", k), 32'(led), 32'(exp_led(k % 24)));
            @(posedge clk);
            #1;
        end
        apb_write(16'h0000, 32'h0, e);
        check("stop_led", 32'(led), 32'h00);
        apb_read(16'h0004, rd, e);
        check("stop_status", rd & 32'h3, 32'h0);
        check("stop_irq", 32'(irq), 32'h0);

        // Software stop lands on the same edge as the natural end: DONE still set
        apb_write(16'h0000, 32'h5, e);
        repeat (21) @(posedge clk);
        apb_write(16'h0000, 32'h0, e);
        check("simend_led", 32'(led), 32'h00);
        apb_read(16'h0004, rd, e);
        check("simend_status", rd & 32'h3, 32'h2);
        apb_write(16'h0004, 32'h2, e);

        // DONE w1c on the same edge as DONE set: set wins
        apb_write(16'h0000, 32'h5, e);
        repeat (21) @(posedge clk);
        apb_write(16'h0004, 32'h2, e);
        apb_read(16'h0004, rd, e);
        check("w1c_race_status", rd & 32'h3, 32'h2);
        check("w1c_race_irq", 32'(irq), 32'h1);
        apb_write(16'h0004, 32'h2, e);

        // Reset in the middle of a run
        apb_write(16'h0000, 32'h5, e);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midreset_led", 32'(led), 32'h00);
        check("midreset_irq", 32'(irq), 32'h0);
        apb_read(16'h0004, rd, e);
        check("midreset_status", rd, 32'h0);
        apb_read(16'h0000, rd, e);
        check("midreset_ctrl", rd, 32'h0);
        apb_read(16'h0040, rd, e);
        check("midreset_step0", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
